// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for eight bus requesters sharing one 32-bit, 8-input datapath mux.
// It keeps the grant until the transaction finishes, with an optional cap on how long one owner may hold it.
module rr_bus_arbiter #(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [2:0]       sel,
    output logic             busy,
    output logic             timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // With the timeout disabled the counter simply parks at all-ones.
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD - 1);

    state_t            state;
    logic [2:0]        last_ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [2:0]        pick;
    logic [2:0]        idx;
    logic              any_req;
    logic              normal_rel;
    logic              timeout_rel;

    // The scan runs from the farthest slot down to the nearest, so the
    // requester closest after last_ptr is the one left in pick.
    always_comb begin
        pick    = last_ptr;
        idx     = '0;
        any_req = |req;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = last_ptr + 3'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

    // Done and a withdrawn request take precedence over the hold limit.
    always_comb begin
        normal_rel  = done | ~req[sel];
        timeout_rel = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    end

    assign busy = |grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            sel      <= '0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            last_ptr <= 3'd7;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (any_req) begin
                        grant    <= N_REQ'(1) << pick;
                        sel      <= pick;
                        hold_cnt <= '0;
                        state    <= OWN;
                    end
                end
                OWN: begin
                    if (normal_rel || timeout_rel) begin
                        grant    <= '0;
                        last_ptr <= sel;
                        timeout  <= ~normal_rel;
                        state    <= IDLE;
                    end else begin
                        timeout <= 1'b0;
                        if (hold_cnt != HOLD_LAST) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter with a cycle-level ownership model checked every cycle.
// The hold limit is shortened to 4 so the forced release is reachable in a few cycles.
module tb_rr_bus_arbiter;

    localparam int MAXH = 4;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;

    int nChecks;
    int nBad;
    bit checkEn;

    // Model state: owner index (-1 when the bus is free), last owner,
    // cycles the current owner has held the grant, and the pulse flag.
    int mOwner;
    int mLast;
    int mHeld;
    int mSel;
    bit mTimeout;

    rr_bus_arbiter #(.N_REQ(8), .MAX_HOLD(MAXH), .HOLD_W(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ownership model advanced on every rising edge from the sampled inputs.
    always @(posedge clk) begin
        if (reset) begin
            mOwner   = -1;
            mLast    = 7;
            mHeld    = 0;
            mSel     = 0;
            mTimeout = 1'b0;
        end else if (mOwner < 0) begin
            mTimeout = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                if (mOwner < 0 && req[(mLast + k) % 8]) begin
                    mOwner = (mLast + k) % 8;
                end
            end
            if (mOwner >= 0) begin
                mSel  = mOwner;
                mHeld = 1;
            end
        end else begin
            if (done || !req[mOwner]) begin
                mLast    = mOwner;
                mOwner   = -1;
                mTimeout = 1'b0;
            end else if (MAXH != 0 && mHeld >= MAXH) begin
                mLast    = mOwner;
                mOwner   = -1;
                mTimeout = 1'b1;
            end else begin
                mHeld    = mHeld + 1;
                mTimeout = 1'b0;
            end
        end
    end

    function automatic logic [7:0] modelGrant();
        return (mOwner >= 0) ? (8'(1) << mOwner) : 8'h00;
    endfunction

    // Every-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (checkEn) begin
            nChecks++;
            if (grant !== modelGrant()) begin
                nBad++;
                $display("[TB] FAIL model_grant t=%0t got=%h want=%h", $time, grant, modelGrant());
            end
            nChecks++;
            if (sel !== 3'(mSel)) begin
                nBad++;
                $display("[TB] FAIL model_sel t=%0t got=%0d want=%0d", $time, sel, mSel);
            end
            nChecks++;
            if (busy !== (mOwner >= 0)) begin
                nBad++;
                $display("[TB] FAIL model_busy t=%0t got=%b want=%b", $time, busy, (mOwner >= 0));
            end
            nChecks++;
            if (timeout !== mTimeout) begin
                nBad++;
                $display("[TB] FAIL model_timeout t=%0t got=%b want=%b", $time, timeout, mTimeout);
            end
            nChecks++;
            if (!$onehot0(grant)) begin
                nBad++;
                $display("[TB] FAIL onehot t=%0t got=%h want=zero_or_onehot", $time, grant);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] r, input logic d, input logic rs);
        req   = r;
        done  = d;
        reset = rs;
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expGrant,
                               input logic [2:0] expSel, input logic expTimeout);
        nChecks++;
        if (grant !== expGrant || sel !== expSel || timeout !== expTimeout) begin
            nBad++;
            $display("[TB] FAIL %s got grant=%h sel=%0d timeout=%b want grant=%h sel=%0d timeout=%b",
                     name, grant, sel, timeout, expGrant, expSel, expTimeout);
        end
    endtask

    initial begin
        nChecks = 0;
        nBad    = 0;
        checkEn = 1'b0;
        req     = '0;
        done    = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #2;
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkEn = 1'b1;
        checkOutput("reset_state", 8'h00, 3'd0, 1'b0);

        $display("[TB] reset priority");
        applyStimulus(8'hFF, 1'b0, 1'b0);
        checkOutput("prio_first", 8'h01, 3'd0, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b0);
        checkOutput("prio_gap", 8'h00, 3'd0, 1'b0);
        applyStimulus(8'hFF, 1'b0, 1'b0);
        checkOutput("prio_second", 8'h02, 3'd1, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("prio_release", 8'h00, 3'd1, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);

        $display("[TB] rotation");
        applyStimulus(8'h00, 1'b0, 1'b1);
        applyStimulus(8'h85, 1'b0, 1'b0);
        checkOutput("rot_0", 8'h01, 3'd0, 1'b0);
        applyStimulus(8'h85, 1'b1, 1'b0);
        checkOutput("rot_gap0", 8'h00, 3'd0, 1'b0);
        applyStimulus(8'h85, 1'b0, 1'b0);
        checkOutput("rot_2", 8'h04, 3'd2, 1'b0);
        applyStimulus(8'h85, 1'b1, 1'b0);
        checkOutput("rot_gap2", 8'h00, 3'd2, 1'b0);
        applyStimulus(8'h85, 1'b0, 1'b0);
        checkOutput("rot_7", 8'h80, 3'd7, 1'b0);
        applyStimulus(8'h85, 1'b1, 1'b0);
        applyStimulus(8'h85, 1'b0, 1'b0);
        checkOutput("rot_wrap", 8'h01, 3'd0, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0);

        $display("[TB] timeout");
        applyStimulus(8'h08, 1'b0, 1'b0);
        checkOutput("to_grant", 8'h08, 3'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h08, 1'b0, 1'b0);
        end
        checkOutput("to_held4", 8'h08, 3'd3, 1'b0);
        applyStimulus(8'h08, 1'b0, 1'b0);
        checkOutput("to_pulse", 8'h00, 3'd3, 1'b1);
        applyStimulus(8'h08, 1'b0, 1'b0);
        checkOutput("to_regrant", 8'h08, 3'd3, 1'b0);

        $display("[TB] withdraw and simultaneous release");
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("withdraw", 8'h00, 3'd3, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        applyStimulus(8'h0A, 1'b0, 1'b0);
        checkOutput("sim_grant1", 8'h02, 3'd1, 1'b0);
        applyStimulus(8'h08, 1'b1, 1'b0);
        checkOutput("sim_release", 8'h00, 3'd1, 1'b0);
        applyStimulus(8'h0C, 1'b0, 1'b0);
        checkOutput("sim_single_adv", 8'h04, 3'd2, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0);

        $display("[TB] reset mid-ownership");
        applyStimulus(8'h20, 1'b0, 1'b0);
        checkOutput("mid_grant5", 8'h20, 3'd5, 1'b0);
        applyStimulus(8'h20, 1'b0, 1'b1);
        checkOutput("mid_reset", 8'h00, 3'd0, 1'b0);
        applyStimulus(8'h30, 1'b0, 1'b0);
        checkOutput("mid_after", 8'h10, 3'd4, 1'b0);

        $display("[TB] stray inputs");
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("idle_done", 8'h00, 3'd4, 1'b0);
        applyStimulus(8'h01, 1'b0, 1'b0);
        checkOutput("stray_grant", 8'h01, 3'd0, 1'b0);
        applyStimulus(8'hFF, 1'b0, 1'b0);
        applyStimulus(8'hF1, 1'b0, 1'b0);
        applyStimulus(8'h01, 1'b0, 1'b0);
        checkOutput("stray_hold", 8'h01, 3'd0, 1'b0);
        applyStimulus(8'h01, 1'b0, 1'b0);
        checkOutput("stray_timeout", 8'h00, 3'd0, 1'b1);

        $display("[TB] done at hold limit");
        applyStimulus(8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h01, 1'b0, 1'b0);
        end
        applyStimulus(8'h01, 1'b1, 1'b0);
        checkOutput("limit_done", 8'h00, 3'd0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
